// File: rtl/posit_pkg.sv
// Shared definitions for the posit packer: default geometry, FSM state
// encoding, result kinds and constant helpers for the saturation/special
// encodings (MAXPOS, MINPOS, NaR) as functions of the posit width.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 3;
    localparam int SCALE_W  = 10;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FILL    = ST_FILL,
        ROUND   = ST_ROUND,
        DONE_ST = ST_DONE
    } state_e;

    // What DONE_ST has to emit
    typedef enum logic [1:0] {
        KIND_NUM  = 2'd0,
        KIND_ZERO = 2'd1,
        KIND_NAR  = 2'd2
    } kind_e;

    // Largest positive posit: 0 followed by n-1 ones
    function automatic logic [63:0] posit_maxpos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Smallest positive posit: 0...01
    function automatic logic [63:0] posit_minpos(input int n);
        return (n > 1) ? 64'd1 : 64'd0;
    endfunction

    // Not-a-Real: 1 followed by n-1 zeros
    function automatic logic [63:0] posit_nar(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Regime values at or beyond which the result saturates
    function automatic logic signed [SCALE_W-1:0] posit_sat_k_hi(input int n);
        return SCALE_W'(n - 2);
    endfunction

    function automatic logic signed [SCALE_W-1:0] posit_sat_k_lo(input int n);
        return SCALE_W'(1 - n);
    endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Combinational rounding of a posit body.
// With POSIT_ENC_RNE_EN defined the body is rounded to nearest, ties to
// even, using the guard and sticky bits; otherwise it is truncated.
// In both builds an all-ones body never increments (MAXPOS is sticky) and
// a zero body is lifted to 1 so a nonzero value never encodes as zero.
module posit_round_rne #(
    parameter int BW = 31
) (
    input  logic [BW-1:0] body_i,
    input  logic          guard_i,
    input  logic          sticky_i,
    output logic [BW-1:0] body_o
);

    logic          inc_d;
    logic [BW-1:0] sum_d;

`ifndef POSIT_ENC_RNE_EN
    // Truncation build: guard and sticky are intentionally ignored
    logic unused_rnd;
    assign unused_rnd = guard_i ^ sticky_i;
`endif

    // Decide on the increment, apply it, then enforce the never-zero floor
    always_comb begin
        inc_d = 1'b0;
`ifdef POSIT_ENC_RNE_EN
        inc_d = guard_i & (sticky_i | body_i[0]) & ~(&body_i);
`endif
        sum_d  = body_i + BW'(inc_d);
        body_o = (sum_d == '0) ? BW'(1) : sum_d;
    end

endmodule

// File: rtl/posit_encoder.sv
// Multi-cycle posit packer: (sign, scale, normalized 64-bit mantissa) to an
// N-bit posit. The regime/exponent/fraction bitstream is built at capture
// time, then shifted out one bit per cycle for exactly N cycles so latency
// is independent of regime length. Saturating and special inputs skip
// straight to the output stage.
// Optional rounding: define POSIT_ENC_RNE_EN for round-to-nearest-even;
// without it the ROUND state truncates.
module posit_encoder
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sign_in,
    input  logic               zero_in,
    input  logic               nar_in,
    input  logic [SCALE_W-1:0] scale_in,
    input  logic [63:0]        mant_in,
    output logic [N-1:0]       posit_out,
    output logic               done,
    output logic               busy
);

    localparam int BW     = N - 1;          // body width (posit minus sign)
    localparam int FRAC_W = 62;             // fraction bits below the hidden bit
    localparam int TAIL_W = ES + FRAC_W;    // exponent + fraction
    localparam int SW     = BW + TAIL_W;    // longest non-saturated stream
    localparam int CNT_W  = $clog2(N + 1);

    localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
    localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));
    localparam logic [N-1:0] NAR    = N'(posit_nar(N));
    localparam logic signed [SCALE_W-1:0] K_HI = posit_sat_k_hi(N);
    localparam logic signed [SCALE_W-1:0] K_LO = posit_sat_k_lo(N);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N - 1);

    // Registered state
    state_e            state_q;
    kind_e             kind_q;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SW-1:0]     stream_q;
    logic [N-1:0]      fill_q;
    logic [BW-1:0]     body_q;
    logic [N-1:0]      posit_q;
    logic              done_q;
    logic              busy_q;

    // Capture-time decode
    logic signed [SCALE_W-1:0] scale_s;
    logic signed [SCALE_W-1:0] k_s;
    logic signed [SCALE_W-1:0] rlen_s;
    logic [ES-1:0]             e_d;
    logic                      sat_hi_d;
    logic                      sat_lo_d;
    logic [SW-1:0]             regime_d;
    logic [SW-1:0]             stream_d;
    int                        k_i;
    int                        rlen_i;

    // Rounding / output staging
    logic                      sticky_d;
    logic [BW-1:0]             body_rnd_d;
    logic [N-1:0]              mag_d;
    logic [N-1:0]              signed_d;

    // The two leading mantissa bits are fixed at 01 by normalization
    logic unused_hdr;
    assign unused_hdr = ^mant_in[63:62];

    // Split scale into regime k and exponent e, detect saturation and
    // lay out the MSB-first stream: regime, then e, then fraction
    always_comb begin
        scale_s  = $signed(scale_in);
        k_s      = scale_s >>> ES;
        e_d      = scale_in[ES-1:0];
        sat_hi_d = (k_s >= K_HI);
        sat_lo_d = (k_s <= K_LO);
        k_i      = int'(k_s);
        rlen_s   = k_s[SCALE_W-1] ? (SCALE_W'(1) - k_s) : (k_s + SCALE_W'(2));
        rlen_i   = int'(rlen_s);
        if (sat_hi_d || sat_lo_d) begin
            // stream is discarded on these paths; keep shift amounts sane
            rlen_i = BW;
            k_i    = 0;
        end
        if (!k_s[SCALE_W-1]) begin
            // k+1 ones followed by a terminating zero
            regime_d = ((SW'(1) << (k_i + 1)) - SW'(1)) << 1;
        end else begin
            // -k zeros followed by a terminating one
            regime_d = SW'(1);
        end
        stream_d = (regime_d << (SW - rlen_i))
                 | (SW'({e_d, mant_in[FRAC_W-1:0]}) << (BW - rlen_i));
    end

    // After N shifts whatever remains in the stream is below the guard
    assign sticky_d = |stream_q;

    posit_round_rne #(
        .BW(BW)
    ) u_round (
        .body_i  (fill_q[N-1:1]),
        .guard_i (fill_q[0]),
        .sticky_i(sticky_d),
        .body_o  (body_rnd_d)
    );

    // Sign application on the final magnitude
    assign mag_d    = {1'b0, body_q};
    assign signed_d = sign_q ? (~mag_d + N'(1)) : mag_d;

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= KIND_NUM;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            stream_q <= '0;
            fill_q   <= '0;
            body_q   <= '0;
            posit_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // the cycle carrying the done pulse never accepts a start
                    if (start && !done_q) begin
                        sign_q <= sign_in;
                        busy_q <= 1'b1;
                        if (nar_in) begin
                            kind_q  <= KIND_NAR;
                            state_q <= DONE_ST;
                        end else if (zero_in) begin
                            kind_q  <= KIND_ZERO;
                            state_q <= DONE_ST;
                        end else if (sat_hi_d) begin
                            kind_q  <= KIND_NUM;
                            body_q  <= MAXPOS[BW-1:0];
                            state_q <= DONE_ST;
                        end else if (sat_lo_d) begin
                            kind_q  <= KIND_NUM;
                            body_q  <= MINPOS[BW-1:0];
                            state_q <= DONE_ST;
                        end else begin
                            kind_q   <= KIND_NUM;
                            stream_q <= stream_d;
                            fill_q   <= '0;
                            cnt_q    <= '0;
                            state_q  <= FILL;
                        end
                    end
                end
                FILL: begin
                    fill_q   <= {fill_q[N-2:0], stream_q[SW-1]};
                    stream_q <= stream_q << 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == FILL_LAST) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    body_q  <= body_rnd_d;
                    state_q <= DONE_ST;
                end
                DONE_ST: begin
                    case (kind_q)
                        KIND_NAR:  posit_q <= NAR;
                        KIND_ZERO: posit_q <= '0;
                        default:   posit_q <= signed_d;
                    endcase
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign posit_out = posit_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (N=32, ES=3) with hand-computed vectors.
// Expected rounding results follow POSIT_ENC_RNE_EN when it is defined.
module tb_posit_encoder;

    localparam int LAT_N = 34;   // normal path: N+2 edges
    localparam int LAT_S = 1;    // special / saturation path

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign_in;
    logic        zero_in;
    logic        nar_in;
    logic [9:0]  scale_in;
    logic [63:0] mant_in;
    logic [31:0] posit_out;
    logic        done;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    posit_encoder #(
        .N (32),
        .ES(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign_in  (sign_in),
        .zero_in  (zero_in),
        .nar_in   (nar_in),
        .scale_in (scale_in),
        .mant_in  (mant_in),
        .posit_out(posit_out),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic encode(input string tag, input logic s, input logic z, input logic n,
                          input logic [9:0] sc, input logic [63:0] m,
                          input logic [31:0] exp_p, input int exp_lat);
        int  lat;
        bit  seen;
        @(negedge clk);
        sign_in  = s;
        zero_in  = z;
        nar_in   = n;
        scale_in = sc;
        mant_in  = m;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_vec({tag, "/busy"}, 64'(busy), 64'd1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1;
        end
        check_vec({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        check_vec({tag, "/val"}, 64'(posit_out), 64'(exp_p));
        @(posedge clk);
        #1;
        check_vec({tag, "/pulse"}, 64'(done), 64'd0);
        check_vec({tag, "/hold"}, 64'(posit_out), 64'(exp_p));
    endtask

    localparam logic [63:0] M_ONE  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] M_TIE  = 64'h4000_0008_0000_0000;
    localparam logic [63:0] M_UP   = 64'h4000_000C_0000_0000;

    initial begin
        int ndone;
        int first_e;
        int second_e;
        int guard_cnt;

        rst_n = 1'b0; start = 1'b0; sign_in = 1'b0; zero_in = 1'b0;
        nar_in = 1'b0; scale_in = '0; mant_in = M_ONE;
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset/posit", 64'(posit_out), 64'd0);
        check_vec("reset/done", 64'(done), 64'd0);
        check_vec("reset/busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic encodings
        encode("s0",      0, 0, 0, 10'd0,       M_ONE, 32'h4000_0000, LAT_N);
        encode("s0neg",   1, 0, 0, 10'd0,       M_ONE, 32'hC000_0000, LAT_N);
        encode("sm1",     0, 0, 0, 10'(-1),     M_ONE, 32'h3C00_0000, LAT_N);
        encode("sm1neg",  1, 0, 0, 10'(-1),     M_ONE, 32'hC400_0000, LAT_N);
        encode("s8",      0, 0, 0, 10'd8,       M_ONE, 32'h6000_0000, LAT_N);

        // Rounding
        encode("tie",     0, 0, 0, 10'd0,       M_TIE, 32'h4000_0000, LAT_N);
`ifdef POSIT_ENC_RNE_EN
        encode("rup",     0, 0, 0, 10'd0,       M_UP,  32'h4000_0001, LAT_N);
        encode("rupneg",  1, 0, 0, 10'd0,       M_UP,  32'hBFFF_FFFF, LAT_N);
`else
        encode("rup",     0, 0, 0, 10'd0,       M_UP,  32'h4000_0000, LAT_N);
        encode("rupneg",  1, 0, 0, 10'd0,       M_UP,  32'hC000_0000, LAT_N);
`endif

        // Regime boundaries just inside and at saturation
        encode("khi29",   0, 0, 0, 10'd232,     M_ONE, 32'h7FFF_FFFE, LAT_N);
        encode("khi30",   0, 0, 0, 10'd240,     M_ONE, 32'h7FFF_FFFF, LAT_S);
        encode("klo30",   0, 0, 0, 10'(-240),   M_ONE, 32'h0000_0001, LAT_N);
        encode("klo31",   0, 0, 0, 10'(-248),   M_ONE, 32'h0000_0001, LAT_S);

        // Saturation and specials
        encode("sat300",  0, 0, 0, 10'd300,     M_ONE, 32'h7FFF_FFFF, LAT_S);
        encode("satm300", 0, 0, 0, 10'(-300),   M_ONE, 32'h0000_0001, LAT_S);
        encode("satneg",  1, 0, 0, 10'd300,     M_ONE, 32'h8000_0001, LAT_S);
        encode("nar",     0, 1, 1, 10'd0,       M_ONE, 32'h8000_0000, LAT_S);
        encode("zero",    1, 1, 0, 10'd0,       M_ONE, 32'h0000_0000, LAT_S);

        // Reset in the middle of FILL aborts without a done pulse
        encode("prerst",  0, 0, 0, 10'd8,       M_ONE, 32'h6000_0000, LAT_N);
        @(negedge clk);
        scale_in = 10'd0; mant_in = M_ONE; sign_in = 1'b0; zero_in = 1'b0; nar_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_vec("midrst/posit", 64'(posit_out), 64'd0);
        check_vec("midrst/busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_vec("midrst/nodone", 64'(ndone), 64'd0);
        encode("postrst", 0, 0, 0, 10'(-1),     M_ONE, 32'h3C00_0000, LAT_N);

        // start held high: one done per acceptance, restart only from IDLE
        @(negedge clk);
        scale_in = 10'd0; mant_in = M_ONE; sign_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        ndone = 0; first_e = -1; second_e = -1;
        for (int i = 1; i <= 75; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_e < 0) first_e = i;
                else if (second_e < 0) second_e = i;
            end
        end
        start = 1'b0;
        check_vec("hold/count", 64'(ndone), 64'd2);
        check_vec("hold/first", 64'(first_e), 64'(LAT_N));
        check_vec("hold/gap_ok", 64'((second_e - first_e) >= LAT_N + 1), 64'd1);
        check_vec("hold/val", 64'(posit_out), 64'h4000_0000);
        guard_cnt = 0;
        while (busy && guard_cnt < 60) begin
            @(posedge clk);
            #1;
            guard_cnt++;
        end
        check_vec("hold/drain", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);

        encode("final",   1, 0, 0, 10'd8,       M_ONE, 32'hA000_0000, LAT_N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Multi-cycle posit packer: turns a normalized (sign, scale, 64-bit mantissa) triple into an N-bit posit word.
- Sits directly downstream of the product normalization stage and consumes its scale/mantissa.
- Performs regime/exponent/fraction serialization, round-to-nearest-even, saturation and two's-complement sign application.

Parameters:
N, 32, posit width in bits
ES, 3, exponent field width; scale[ES-1:0] is the exponent, scale>>>ES is regime k

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
sign_in  input  1  result sign (1 = negative)
zero_in  input  1  result is exact zero
nar_in  input  1  result is NaR; priority over zero_in
scale_in  input  10  signed two's-complement scale
mant_in  input  64  normalized mantissa; bits[63:62]==2'b01, hidden bit at 62, fraction mant_in[61:0]
posit_out  output  N  encoded posit; holds until next completion
done  output  1  one-cycle completion pulse
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: clk-synchronous, rst_n low -> state IDLE; posit_out=0, done=0, busy=0, all internal registers 0.
  - Reset mid-operation aborts; no done is produced.
- States: IDLE, FILL, ROUND, DONE_ST.
- IDLE:
  - start=1 captures all inputs.
  - nar_in, zero_in or saturation -> DONE_ST; otherwise -> FILL.
  - start in any other state is ignored (not queued).
- k = scale_in >>> ES (arithmetic); e = scale_in[ES-1:0].
- Saturation:
  - k >= N-2 -> magnitude MAXPOS (0 followed by N-1 ones).
  - k <= -(N-1) -> magnitude MINPOS (0...01).
- Body bitstream, N-1 bits after the sign:
  - regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - then e MSB-first, then mant[61:0] MSB-first.
- FILL:
  - Exactly N cycles; one stream bit shifted into a body register per cycle.
  - The first N-1 bits are the body; bit N is the guard.
  - Sticky = OR of all unconsumed stream bits.
  - Regime length does not change latency.
- ROUND:
  - Increment body if guard & (sticky | body[0]).
  - Body all ones never increments (saturates at MAXPOS).
  - Body 0 is forced to 1 (never round to zero).
- DONE_ST:
  - posit_out <= sign ? two's complement of {0,body} : {0,body}; done <= 1 for this cycle only.
  - NaR -> {1,0...0}; zero -> 0 (sign ignored).
  - Next state IDLE.
- Latency: normal path has done high N+2 edges after the start-sampling edge; special and saturation paths have done high 1 edge after it.
- start asserted in the cycle done is high (state DONE_ST) is ignored; it is accepted only once back in IDLE.

Optional Feature:
- POSIT_ENC_RNE_EN defined: ROUND applies round-to-nearest-even as above.
- Undefined: ROUND state is still traversed (latency identical) but never increments (truncation); the body-0 -> 1 guard remains.

Decomposition:
- Shared package posit_pkg:
  - N/ES defaults, state encoding localparams.
  - MAXPOS/MINPOS/NAR constant functions of N, scale width (10).
- One natural sub-module: posit_round_rne, combinational {body, guard, sticky} -> rounded body, gated by the macro.

Test Plan:
- Reset: rst_n low 3 cycles mid-FILL -> posit_out=0, done never pulses; next start behaves normally.
- scale=0, mant=0x4000_0000_0000_0000, sign=0 -> 0x40000000.
- Same with sign=1 -> 0xC0000000.
- scale=-1 -> 0x3C000000.
- scale=8 -> 0x60000000.
- Latency: each normal case has done high exactly 34 edges after start, for 1 cycle.
- Rounding, scale=0:
  - mant=0x4000_0008_0000_0000 -> 0x40000000 (tie to even).
  - mant=0x4000_000C_0000_0000 -> 0x40000001 (with the macro); 0x40000000 without it.
- Saturation/specials, each with done 1 edge after start:
  - scale=300 -> 0x7FFFFFFF.
  - scale=-300 -> 0x00000001.
  - nar_in=1 with zero_in=1 -> 0x80000000.
  - zero_in=1, sign=1 -> 0x00000000.
- Busy start: start held high through an entire operation -> exactly one done per IDLE acceptance; the second encode begins only after returning to IDLE.
